// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if : requester, response, ALU and status bundle for alu_arbiter
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface alu_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req_a0;
  logic [DATA_W-1:0] req_a1;
  logic [DATA_W-1:0] req_b0;
  logic [DATA_W-1:0] req_b1;
  logic [DATA_W-1:0] req_imm0;
  logic [DATA_W-1:0] req_imm1;
  logic [2:0]        req_op0;
  logic [2:0]        req_op1;
  logic              req_src0;
  logic              req_src1;

  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DATA_W-1:0] rsp_res;
  logic              rsp_zero;
  logic              rsp_err;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_imm;
  logic [2:0]        alu_op;
  logic              alu_src;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;

  logic              busy;

  // Environment side: requesters plus the shared combinational ALU.
  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, req_imm0, req_imm1,
           req_op0, req_op1, req_src0, req_src1, rsp_ready, alu_res, alu_zero,
    input  req_ready, rsp_valid, rsp_res, rsp_zero, rsp_err,
           alu_a, alu_b, alu_imm, alu_op, alu_src, busy
  );

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, req_imm0, req_imm1,
           req_op0, req_op1, req_src0, req_src1, rsp_ready, alu_res, alu_zero,
    output req_ready, rsp_valid, rsp_res, rsp_zero, rsp_err,
           alu_a, alu_b, alu_imm, alu_op, alu_src, busy
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter : two-requester round-robin front end for one shared ALU
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
  parameter int         DATA_W = 32,
  parameter logic [2:0] MAX_OP = 3'b100
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic              prio_q;
  logic              gnt_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] imm_q;
  logic [2:0]        op_q;
  logic              src_q;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp_res_q;
  logic              rsp_zero_q;
  logic              rsp_err_q;

  logic              gnt_idx_d;
  logic [1:0]        gnt_oh_d;
  logic [1:0]        ready_d;
  logic              accept_d;
  logic [DATA_W-1:0] sel_a_d;
  logic [DATA_W-1:0] sel_b_d;
  logic [DATA_W-1:0] sel_imm_d;
  logic [2:0]        sel_op_d;
  logic              sel_src_d;
  logic              legal_d;
  logic              rsp_hs_d;

  // prio_q names the requester that wins when both are valid.
  always_comb begin
    gnt_idx_d = 1'b0;
    gnt_oh_d  = 2'b00;
    case (bus.req_valid)
      2'b01: begin
        gnt_idx_d = 1'b0;
        gnt_oh_d  = 2'b01;
      end
      2'b10: begin
        gnt_idx_d = 1'b1;
        gnt_oh_d  = 2'b10;
      end
      2'b11: begin
        gnt_idx_d = prio_q;
        gnt_oh_d  = prio_q ? 2'b10 : 2'b01;
      end
      default: begin
        gnt_idx_d = 1'b0;
        gnt_oh_d  = 2'b00;
      end
    endcase
  end

  assign ready_d  = ((state_q == IDLE) && rst_n) ? gnt_oh_d : 2'b00;
  assign accept_d = |ready_d;

  assign sel_a_d   = gnt_idx_d ? bus.req_a1   : bus.req_a0;
  assign sel_b_d   = gnt_idx_d ? bus.req_b1   : bus.req_b0;
  assign sel_imm_d = gnt_idx_d ? bus.req_imm1 : bus.req_imm0;
  assign sel_op_d  = gnt_idx_d ? bus.req_op1  : bus.req_op0;
  assign sel_src_d = gnt_idx_d ? bus.req_src1 : bus.req_src0;
  assign legal_d   = (sel_op_d <= MAX_OP);

  // rsp_valid_q is one-hot to the owner, so the other rsp_ready bit is masked.
  assign rsp_hs_d = |(rsp_valid_q & bus.rsp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      gnt_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      op_q        <= 3'b000;
      src_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_res_q   <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            gnt_q <= gnt_idx_d;
            if (legal_d) begin
              a_q     <= sel_a_d;
              b_q     <= sel_b_d;
              imm_q   <= sel_imm_d;
              op_q    <= sel_op_d;
              src_q   <= sel_src_d;
              state_q <= EXEC;
            end else begin
              // Illegal opcode: ALU drive keeps its previous operation.
              rsp_valid_q <= gnt_oh_d;
              rsp_res_q   <= '0;
              rsp_zero_q  <= 1'b0;
              rsp_err_q   <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        EXEC: begin
          rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
          rsp_res_q   <= bus.alu_res;
          rsp_zero_q  <= bus.alu_zero;
          rsp_err_q   <= 1'b0;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_hs_d) begin
            rsp_valid_q <= 2'b00;
            prio_q      <= ~gnt_q;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_d;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_imm   = imm_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_src   = src_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter : directed bench for alu_arbiter with a behavioural ALU
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(32)) bus ();

  alu_arbiter #(.DATA_W(32), .MAX_OP(3'b100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor; src selects imm for b.
  logic [31:0] alu_opb;
  assign alu_opb = bus.alu_src ? bus.alu_imm : bus.alu_b;
  always_comb begin
    bus.alu_res = 32'd0;
    case (bus.alu_op)
      3'd0:    bus.alu_res = bus.alu_a + alu_opb;
      3'd1:    bus.alu_res = bus.alu_a - alu_opb;
      3'd2:    bus.alu_res = bus.alu_a & alu_opb;
      3'd3:    bus.alu_res = bus.alu_a | alu_opb;
      default: bus.alu_res = bus.alu_a ^ alu_opb;
    endcase
  end
  assign bus.alu_zero = (bus.alu_res == 32'd0);

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b want 00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got %b want 00", bus.rsp_valid); end
    checks++; if (bus.rsp_res !== 32'd0) begin errors++; $display("FAIL rst_res got %0d want 0", bus.rsp_res); end
    checks++; if ({bus.rsp_zero, bus.rsp_err, bus.busy} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {bus.rsp_zero, bus.rsp_err, bus.busy}); end
    checks++; if ({bus.alu_a, bus.alu_op, bus.alu_src} !== 36'd0) begin errors++; $display("FAIL rst_alu got %h want 0", {bus.alu_a, bus.alu_op, bus.alu_src}); end
    bus.req_valid = 2'b00;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    step();
    bus.req_a0 = 32'd5; bus.req_b0 = 32'd3; bus.req_op0 = 3'd0; bus.req_src0 = 1'b0;
    bus.req_valid = 2'b01; bus.rsp_ready = 2'b00;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL add_ready got %b want 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00; bus.req_a0 = 32'd99;
    #1;
    checks++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b1) begin errors++; $display("FAIL add_exec got valid=%b busy=%b want 00/1", bus.rsp_valid, bus.busy); end
    checks++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd3) begin errors++; $display("FAIL add_alu got a=%0d b=%0d want 5/3", bus.alu_a, bus.alu_b); end
    step();
    checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL add_valid got %b want 01", bus.rsp_valid); end
    checks++; if (bus.rsp_res !== 32'd8 || bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL add_res got %0d z=%b e=%b want 8/0/0", bus.rsp_res, bus.rsp_zero, bus.rsp_err); end
    bus.rsp_ready = 2'b01;
    step();
    checks++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL add_done got valid=%b busy=%b want 00/0", bus.rsp_valid, bus.busy); end
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_sub_imm();
    step();
    bus.req_a1 = 32'd7; bus.req_b1 = 32'd100; bus.req_imm1 = 32'd7; bus.req_src1 = 1'b1; bus.req_op1 = 3'd1;
    bus.req_valid = 2'b10;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL sub_ready got %b want 10", bus.req_ready); end
    step();
    bus.req_valid = 2'b00; bus.rsp_ready = 2'b01;
    step();
    checks++; if (bus.rsp_valid !== 2'b10) begin errors++; $display("FAIL sub_valid got %b want 10", bus.rsp_valid); end
    checks++; if (bus.rsp_res !== 32'd0 || bus.rsp_zero !== 1'b1) begin errors++; $display("FAIL sub_res got %0d z=%b want 0/1", bus.rsp_res, bus.rsp_zero); end
    step();
    checks++; if (bus.rsp_valid !== 2'b10) begin errors++; $display("FAIL sub_foreign_ready got %b want 10", bus.rsp_valid); end
    bus.rsp_ready = 2'b10;
    step();
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL sub_done got %b want 00", bus.rsp_valid); end
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_illegal();
    step();
    bus.req_a0 = 32'd1; bus.req_b0 = 32'd2; bus.req_op0 = 3'b110; bus.req_src0 = 1'b0;
    bus.req_valid = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL ill_ready got %b want 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    #1;
    checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL ill_valid got %b want 01", bus.rsp_valid); end
    checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_res !== 32'd0 || bus.rsp_zero !== 1'b0) begin errors++; $display("FAIL ill_res got e=%b r=%0d z=%b want 1/0/0", bus.rsp_err, bus.rsp_res, bus.rsp_zero); end
    checks++; if (bus.alu_op !== 3'd1 || bus.alu_a !== 32'd7) begin errors++; $display("FAIL ill_alu got op=%0d a=%0d want 1/7", bus.alu_op, bus.alu_a); end
    bus.rsp_ready = 2'b01;
    step();
    checks++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL ill_done got valid=%b busy=%b want 00/0", bus.rsp_valid, bus.busy); end
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_back_to_back();
    step();
    bus.req_a0 = 32'd10; bus.req_b0 = 32'd20; bus.req_op0 = 3'd0; bus.req_src0 = 1'b0;
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b10;
    bus.req_a1 = 32'd9; bus.req_b1 = 32'd4; bus.req_op1 = 3'd3; bus.req_src1 = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL stall_exec_ready got %b want 00", bus.req_ready); end
    step();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_res !== 32'd30 || bus.req_ready !== 2'b00 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d] got valid=%b res=%0d ready=%b busy=%b want 01/30/00/1",
                 i, bus.rsp_valid, bus.rsp_res, bus.req_ready, bus.busy);
      end
      if (i < 5) step();
    end
    bus.rsp_ready = 2'b01;
    step();
    checks++; if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b10) begin errors++; $display("FAIL b2b_ready got valid=%b ready=%b want 00/10", bus.rsp_valid, bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    step();
    checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_res !== 32'd13) begin errors++; $display("FAIL b2b_res got valid=%b res=%0d want 10/13", bus.rsp_valid, bus.rsp_res); end
    bus.rsp_ready = 2'b10;
    step();
    bus.rsp_ready = 2'b00;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_done got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [31:0] exp_r;
    step();
    bus.req_a0 = 32'd1; bus.req_b0 = 32'd1; bus.req_op0 = 3'd0; bus.req_src0 = 1'b0;
    bus.req_a1 = 32'd4; bus.req_b1 = 32'd1; bus.req_op1 = 3'd1; bus.req_src1 = 1'b0;
    bus.req_valid = 2'b11; bus.rsp_ready = 2'b11; rst_n = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rr_reset_ready got %b want 00", bus.req_ready); end
    step();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) begin
      exp_g = (((k / 3) % 2) == 1) ? 2'b10 : 2'b01;
      exp_r = (exp_g == 2'b01) ? 32'd2 : 32'd3;
      checks++;
      if (bus.req_ready !== ((k % 3 == 0) ? exp_g : 2'b00) || bus.busy !== (k % 3 != 0)) begin
        errors++;
        $display("FAIL rr_grant[%0d] got ready=%b busy=%b want grant %b slot %0d", k, bus.req_ready, bus.busy, exp_g, k % 3);
      end
      if (k % 3 == 2) begin
        checks++;
        if (bus.rsp_valid !== exp_g || bus.rsp_res !== exp_r) begin
          errors++;
          $display("FAIL rr_rsp[%0d] got valid=%b res=%0d want %b/%0d", k, bus.rsp_valid, bus.rsp_res, exp_g, exp_r);
        end
      end
      if (k < 11) step();
    end
    bus.req_valid = 2'b00;
    step();
    bus.rsp_ready = 2'b00;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_done got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_reset_exec();
    step();
    bus.req_a0 = 32'd2; bus.req_b0 = 32'd2; bus.req_op0 = 3'd0; bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b00;
    step();
    bus.rsp_ready = 2'b01;
    step();
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL rex_prio got %b want 10", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0 || bus.req_ready !== 2'b00) begin errors++; $display("FAIL rex_clear got valid=%b busy=%b ready=%b want 00/0/00", bus.rsp_valid, bus.busy, bus.req_ready); end
    checks++; if (bus.alu_a !== 32'd0 || bus.alu_op !== 3'd0 || bus.rsp_res !== 32'd0) begin errors++; $display("FAIL rex_alu got a=%0d op=%0d res=%0d want 0/0/0", bus.alu_a, bus.alu_op, bus.rsp_res); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL rex_quiet[%0d] got valid=%b busy=%b want 00/0", i, bus.rsp_valid, bus.busy); end
    end
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rex_next got %b want 01", bus.req_ready); end
    bus.req_valid = 2'b00;
  endtask

  initial begin
    bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
    bus.req_a0 = '0; bus.req_a1 = '0; bus.req_b0 = '0; bus.req_b1 = '0;
    bus.req_imm0 = '0; bus.req_imm1 = '0; bus.req_op0 = '0; bus.req_op1 = '0;
    bus.req_src0 = 1'b0; bus.req_src1 = 1'b0;
    test_reset();
    test_add();
    test_sub_imm();
    test_illegal();
    test_back_to_back();
    test_round_robin();
    test_reset_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
